// File: rtl/mdio_arbiter_if.sv
// rtl/mdio_arbiter_if.sv - command/status bundle between the MDIO arbiter and the MDIO engine
interface mdio_arbiter_if;
  logic        req_enb;
  logic [1:0]  req_op;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] data_phy;
  logic        work_flag;
  logic [15:0] data_sta;
  logic        sta_enb;

  modport master (
    output req_enb, req_op, phy_addr, reg_addr, data_phy,
    input  work_flag, data_sta, sta_enb
  );

  modport slave (
    input  req_enb, req_op, phy_addr, reg_addr, data_phy,
    output work_flag, data_sta, sta_enb
  );
endinterface

// File: rtl/mdio_arbiter.sv
// rtl/mdio_arbiter.sv - round-robin arbiter sharing one MDIO engine among NREQ requesters
module mdio_arbiter #(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      rq_valid,
  input  logic [2*NREQ-1:0]    rq_op,
  input  logic [5*NREQ-1:0]    rq_phy,
  input  logic [5*NREQ-1:0]    rq_reg,
  input  logic [16*NREQ-1:0]   rq_wdata,
  output logic [NREQ-1:0]      rq_done,
  output logic [NREQ-1:0]      rq_err,
  output logic [15:0]          rq_rdata,
  output logic                 arb_busy,
  mdio_arbiter_if.master       mdio
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   last_grant, grant, pick;
  logic            found, done_now, err_now, rd_seen, tmo_hit;
  logic [TW-1:0]   tmo_cnt;
  logic [GW:0]     sum;
  logic [1:0]      op_a    [NREQ];
  logic [4:0]      phy_a   [NREQ];
  logic [4:0]      reg_a   [NREQ];
  logic [15:0]     wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g]    = rq_op[g*2 +: 2];
    assign phy_a[g]   = rq_phy[g*5 +: 5];
    assign reg_a[g]   = rq_reg[g*5 +: 5];
    assign wdata_a[g] = rq_wdata[g*16 +: 16];
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, last_grant} + (GW+1)'(i);
      if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
      if (!found && rq_valid[sum[GW-1:0]]) begin
        found = 1'b1;
        pick  = sum[GW-1:0];
      end
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_now = 1'b0;
    err_now  = 1'b0;
    case (state)
      IDLE: begin
        if (found && !mdio.work_flag)
          state_nx = (op_a[pick] == 2'b01 || op_a[pick] == 2'b10) ? ISSUE : RESP;
      end
      ISSUE: state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tmo_hit) begin
          err_now  = 1'b1;
          state_nx = IDLE;
        end else if (mdio.work_flag) begin
          state_nx = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tmo_hit) begin
          err_now  = 1'b1;
          state_nx = IDLE;
        end else if (!mdio.work_flag) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
        if (mdio.req_op == 2'b01 || (mdio.req_op == 2'b10 && rd_seen)) done_now = 1'b1;
        else                                                           err_now  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant    <= GW'(NREQ - 1);
      grant         <= '0;
      mdio.req_op   <= '0;
      mdio.phy_addr <= '0;
      mdio.reg_addr <= '0;
      mdio.data_phy <= '0;
      rq_rdata      <= '0;
      rd_seen       <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      if (state == IDLE && state_nx != IDLE) begin
        grant         <= pick;
        last_grant    <= pick;
        mdio.req_op   <= op_a[pick];
        mdio.phy_addr <= phy_a[pick];
        mdio.reg_addr <= reg_a[pick];
        mdio.data_phy <= wdata_a[pick];
        rd_seen       <= 1'b0;
      end
      if (state == ISSUE)
        tmo_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
        tmo_cnt <= tmo_cnt + 1'b1;
      // Capture even in the cycle work_flag drops so a late strobe is not lost.
      if (state == WAIT_DONE && mdio.sta_enb) begin
        rq_rdata <= mdio.data_sta;
        rd_seen  <= 1'b1;
      end
    end
  end

  always_comb begin
    rq_done        = '0;
    rq_err         = '0;
    rq_done[grant] = done_now;
    rq_err[grant]  = err_now;
  end

  assign mdio.req_enb = (state == ISSUE);
  assign arb_busy     = (state != IDLE);

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb/tb_mdio_arbiter.sv - directed self-checking bench for mdio_arbiter
module tb_mdio_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      rq_valid;
  logic [2*NREQ-1:0]    rq_op;
  logic [5*NREQ-1:0]    rq_phy;
  logic [5*NREQ-1:0]    rq_reg;
  logic [16*NREQ-1:0]   rq_wdata;
  logic [NREQ-1:0]      rq_done;
  logic [NREQ-1:0]      rq_err;
  logic [15:0]          rq_rdata;
  logic                 arb_busy;

  mdio_arbiter_if mdio();

  mdio_arbiter #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .rq_valid (rq_valid),
    .rq_op    (rq_op),
    .rq_phy   (rq_phy),
    .rq_reg   (rq_reg),
    .rq_wdata (rq_wdata),
    .rq_done  (rq_done),
    .rq_err   (rq_err),
    .rq_rdata (rq_rdata),
    .arb_busy (arb_busy),
    .mdio     (mdio.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input logic [1:0] op,
                         input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
    rq_valid[r]         = v;
    rq_op[r*2 +: 2]     = op;
    rq_phy[r*5 +: 5]    = phy;
    rq_reg[r*5 +: 5]    = rg;
    rq_wdata[r*16 +: 16] = wd;
  endtask

  task automatic wait_enb(input string tag, input int exp_lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      if (mdio.req_enb) seen = 1'b1;
      else n++;
    end
    check({tag, "_enb_lat"}, n, exp_lat);
  endtask

  // Engine accepts the command, stays busy one cycle, then drops work_flag
  // together with an optional status strobe; response is checked one cycle later.
  task automatic engine(input string tag, input bit give_sta, input logic [15:0] sd,
                        input logic [3:0] exp_done, input logic [3:0] exp_err,
                        input logic [15:0] exp_rd);
    @(negedge clk);
    check({tag, "_enb_once"}, mdio.req_enb, 1'b0);
    mdio.work_flag = 1'b1;
    @(negedge clk);
    check({tag, "_no_early"}, rq_done | rq_err, 4'b0000);
    mdio.work_flag = 1'b0;
    mdio.sta_enb   = give_sta;
    mdio.data_sta  = sd;
    @(negedge clk);
    mdio.sta_enb   = 1'b0;
    check({tag, "_done"}, rq_done, exp_done);
    check({tag, "_err"}, rq_err, exp_err);
    check({tag, "_rdata"}, rq_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] acc;
    reset          = 1'b0;
    rq_valid       = '0;
    rq_op          = '0;
    rq_phy         = '0;
    rq_reg         = '0;
    rq_wdata       = '0;
    mdio.work_flag = 1'b0;
    mdio.data_sta  = '0;
    mdio.sta_enb   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", arb_busy, 1'b0);
    check("rst_enb", mdio.req_enb, 1'b0);
    check("rst_op", mdio.req_op, 2'b00);
    check("rst_phy", mdio.phy_addr, 5'h00);
    check("rst_reg", mdio.reg_addr, 5'h00);
    check("rst_data", mdio.data_phy, 16'h0000);
    check("rst_resp", rq_done | rq_err, 4'b0000);
    check("rst_rdata", rq_rdata, 16'h0000);
    reset = 1'b1;
    @(negedge clk);

    // Engine owned elsewhere: no grant while work_flag is high.
    mdio.work_flag = 1'b1;
    set_req(1, 1'b1, 2'b01, 5'h01, 5'h00, 16'h8000);
    repeat (3) @(negedge clk);
    check("busy_no_grant", arb_busy, 1'b0);
    mdio.work_flag = 1'b0;

    wait_enb("wr", 0);
    check("wr_op", mdio.req_op, 2'b01);
    check("wr_phy", mdio.phy_addr, 5'h01);
    check("wr_reg", mdio.reg_addr, 5'h00);
    check("wr_data", mdio.data_phy, 16'h8000);
    rq_valid[1] = 1'b0;
    engine("wr", 1'b0, 16'h0000, 4'b0010, 4'b0000, 16'h0000);
    @(negedge clk);
    check("wr_idle", arb_busy, 1'b0);

    set_req(2, 1'b1, 2'b10, 5'h02, 5'h01, 16'h0000);
    wait_enb("rd", 0);
    check("rd_op", mdio.req_op, 2'b10);
    check("rd_reg", mdio.reg_addr, 5'h01);
    engine("rd", 1'b1, 16'h796D, 4'b0100, 4'b0000, 16'h796D);
    rq_valid[2] = 1'b0;
    @(negedge clk);

    set_req(3, 1'b1, 2'b01, 5'h03, 5'h03, 16'h1234);
    wait_enb("tmo", 0);
    n = 0;
    while (rq_err == 4'b0000 && n < TMO + 8) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, TMO);
    check("tmo_err", rq_err, 4'b1000);
    rq_valid[3] = 1'b0;
    @(negedge clk);
    check("tmo_idle", arb_busy, 1'b0);
    check("tmo_err_clr", rq_err, 4'b0000);

    set_req(0, 1'b1, 2'b10, 5'h00, 5'h04, 16'h0000);
    wait_enb("rdnosta", 0);
    engine("rdnosta", 1'b0, 16'hFFFF, 4'b0000, 4'b0001, 16'h796D);
    rq_valid[0] = 1'b0;
    @(negedge clk);

    set_req(2, 1'b1, 2'b11, 5'h02, 5'h02, 16'h0000);
    @(negedge clk);
    check("op11_err", rq_err, 4'b0100);
    check("op11_done", rq_done, 4'b0000);
    check("op11_enb", mdio.req_enb, 1'b0);
    rq_valid[2] = 1'b0;
    @(negedge clk);
    check("op11_enb2", mdio.req_enb, 1'b0);
    check("op11_idle", arb_busy, 1'b0);

    // Reset while the engine is mid-transaction.
    set_req(1, 1'b1, 2'b01, 5'h11, 5'h05, 16'hABCD);
    wait_enb("rst", 0);
    @(negedge clk);
    mdio.work_flag = 1'b1;
    @(negedge clk);
    check("pre_rst_busy", arb_busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", arb_busy, 1'b0);
    check("mid_rst_phy", mdio.phy_addr, 5'h00);
    check("mid_rst_data", mdio.data_phy, 16'h0000);
    check("mid_rst_op", mdio.req_op, 2'b00);
    check("mid_rst_rdata", rq_rdata, 16'h0000);
    check("mid_rst_resp", rq_done | rq_err, 4'b0000);
    rq_valid[1] = 1'b0;
    mdio.work_flag = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    acc = '0;
    repeat (3) begin
      @(negedge clk);
      acc = acc | rq_done | rq_err;
    end
    check("post_rst_resp", acc, 4'b0000);

    for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 2'b01, 5'(r + 8), 5'(r), 16'(r));
    for (int k = 0; k < 5; k++) begin
      int exp_g;
      exp_g = k % NREQ;
      wait_enb($sformatf("fair%0d", k), (k == 0) ? 0 : 1);
      check($sformatf("fair%0d_phy", k), mdio.phy_addr, 5'(exp_g + 8));
      engine($sformatf("fair%0d", k), 1'b0, 16'h0000, 4'(1 << exp_g), 4'b0000, 16'h0000);
    end
    rq_valid = '0;
    @(negedge clk);
    check("fair_idle", arb_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter TMO_CYC, default 4096, max cycles per transaction from issue to engine idle.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rq_valid  input  NREQ  per-requester request, level, held until rq_done/rq_err.
REQ-006 SHALL have port rq_op  input  2*NREQ  per-requester op: [1]=read, [0]=write.
REQ-007 SHALL have port rq_phy  input  5*NREQ  per-requester PHY address.
REQ-008 SHALL have port rq_reg  input  5*NREQ  per-requester register address.
REQ-009 SHALL have port rq_wdata  input  16*NREQ  per-requester write data.
REQ-010 SHALL have port rq_done  output  NREQ  one-cycle success pulse to the granted requester.
REQ-011 SHALL have port rq_err  output  NREQ  one-cycle failure pulse to the granted requester.
REQ-012 SHALL have port rq_rdata  output  16  read data, valid in the rq_done cycle of a read.
REQ-013 SHALL have port req_enb  output  1  one-cycle start strobe to MDIO engine.
REQ-014 SHALL have ports req_op/phy_addr/reg_addr/data_phy  output  2/5/5/16  engine command, held stable from issue until transaction end.
REQ-015 SHALL have port work_flag  input  1  engine busy (1=busy).
REQ-016 SHALL have ports data_sta/sta_enb  input  16/1  engine read data and its valid strobe.
REQ-017 SHALL have port arb_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-019 IDLE: if any rq_valid and work_flag=0, SHALL grant one requester round-robin (search starts at last_grant+1, wraps at NREQ-1 -> 0), latch its op/phy/reg/wdata, go ISSUE.
REQ-020 IDLE with work_flag=1 SHALL not grant (engine owned elsewhere).
REQ-021 ISSUE: SHALL assert req_enb for exactly one cycle, clear timeout counter, go WAIT_BUSY.
REQ-022 WAIT_BUSY: work_flag=1 -> WAIT_DONE.
REQ-023 WAIT_DONE: on sta_enb=1 SHALL capture data_sta into rq_rdata and set rd_seen; work_flag=0 -> RESP.
REQ-024 sta_enb coincident with work_flag falling SHALL still be captured.
REQ-025 RESP (one cycle): SHALL pulse rq_done[g] if write, or read with rd_seen; else pulse rq_err[g]; then IDLE.
REQ-026 Timeout counter SHALL count every cycle in WAIT_BUSY and WAIT_DONE; reaching TMO_CYC-1 SHALL pulse rq_err[g] and return to IDLE without waiting.
REQ-027 Latched op 2'b00 or 2'b11 SHALL skip ISSUE (no req_enb) and go straight to RESP with rq_err[g].
REQ-028 last_grant SHALL update at grant time; grant index SHALL not change until return to IDLE.
REQ-029 Deassertion of rq_valid[g] mid-transaction SHALL NOT abort; response pulse SHALL still be issued.
REQ-030 Earliest re-grant SHALL be the cycle after RESP; at most one rq_done/rq_err bit SHALL be high per cycle.
REQ-031 Minimum transaction latency SHALL be: grant -> req_enb +1 cycle; rq_done 1 cycle after work_flag falls.
REQ-032 rq_rdata SHALL hold its last captured value until next read capture.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE, last_grant=NREQ-1, req_enb=0, req_op=0, phy_addr=0, reg_addr=0, data_phy=0, rq_done=0, rq_err=0, rq_rdata=0, arb_busy=0, timeout counter=0.
REQ-034 Reset mid-transaction SHALL drop the transaction with no response pulse; first grant after release SHALL be requester 0.

Verification
REQ-035 Single write: rq_valid[1], op=01, phy=5'h01, reg=5'h00, wdata=16'h8000 -> one req_enb with same fields; rq_done[1] one cycle after work_flag falls.
REQ-036 Read: rq_valid[2], op=10, reg=5'h01, engine returns data_sta=16'h796D with sta_enb -> rq_done[2], rq_rdata=16'h796D.
REQ-037 Fairness: all 4 rq_valid held high -> grant order 0,1,2,3,0; no requester starved.
REQ-038 Engine stuck: work_flag never rises -> rq_err[g] pulse TMO_CYC cycles after req_enb, FSM back to IDLE.
REQ-039 Read without sta_enb, and op=11 request -> rq_err pulses; op=11 produces no req_enb.
REQ-040 Reset asserted in WAIT_DONE -> all outputs zero immediately, no response pulse, next grant goes to requester 0.
